// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter: grants the highest {mode,prio} interrupt request and holds it for the core handshake.
// Define CLIC_ARB_RR_TIEBREAK_EN for a round-robin tie-break among equal keys (default: lowest index wins).
module clic_irq_arbiter #(
  parameter int unsigned N_TGT     = 4,
  parameter int unsigned SrcWidth  = 8,
  parameter int unsigned PrioWidth = 8,
  parameter int unsigned ModeWidth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_TGT-1:0]             req_valid_i,
  output logic [N_TGT-1:0]             req_ready_o,
  input  logic [N_TGT*SrcWidth-1:0]    req_id_i,
  input  logic [N_TGT*PrioWidth-1:0]   req_max_i,
  input  logic [N_TGT*ModeWidth-1:0]   req_mode_i,
  input  logic [N_TGT-1:0]             req_kill_req_i,
  output logic [N_TGT-1:0]             req_kill_ack_o,
  output logic                         irq_valid_o,
  input  logic                         irq_ready_i,
  output logic [SrcWidth-1:0]          irq_id_o,
  output logic [PrioWidth-1:0]         irq_max_o,
  output logic [ModeWidth-1:0]         irq_mode_o,
  output logic [$clog2(N_TGT)-1:0]     irq_tgt_o,
  output logic                         irq_kill_req_o,
  input  logic                         irq_kill_ack_i
);

  localparam int unsigned TW = $clog2(N_TGT);
  localparam int unsigned KW = ModeWidth + PrioWidth;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic                   kill_q, kill_d;
  logic [TW-1:0]          tgt_q, tgt_d;
  logic [SrcWidth-1:0]    id_q, id_d;
  logic [PrioWidth-1:0]   max_q, max_d;
  logic [ModeWidth-1:0]   mode_q, mode_d;
`ifdef CLIC_ARB_RR_TIEBREAK_EN
  logic [TW-1:0]          ptr_q, ptr_d;
  int unsigned            rr_idx;
`endif

  logic [KW-1:0]          key [N_TGT];
  logic                   win_found;
  logic [TW-1:0]          win_idx;
  logic [KW-1:0]          win_key;
  logic                   preempt;

  always_comb begin
    for (int i = 0; i < N_TGT; i++) begin
      key[i] = {req_mode_i[i*ModeWidth +: ModeWidth], req_max_i[i*PrioWidth +: PrioWidth]};
    end
  end

  // Strict '>' keeps the first channel visited among equal keys.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_key   = '0;
`ifdef CLIC_ARB_RR_TIEBREAK_EN
    rr_idx    = 0;
    for (int k = 0; k < N_TGT; k++) begin
      rr_idx = (int'(ptr_q) + k) % N_TGT;
      if (req_valid_i[rr_idx] && (!win_found || key[rr_idx] > win_key)) begin
        win_found = 1'b1;
        win_idx   = TW'(rr_idx);
        win_key   = key[rr_idx];
      end
    end
`else
    for (int i = 0; i < N_TGT; i++) begin
      if (req_valid_i[i] && (!win_found || key[i] > win_key)) begin
        win_found = 1'b1;
        win_idx   = TW'(i);
        win_key   = key[i];
      end
    end
`endif
  end

  always_comb begin
    preempt = 1'b0;
    for (int j = 0; j < N_TGT; j++) begin
      if (req_valid_i[j] && (TW'(j) != tgt_q) && (key[j] > {mode_q, max_q})) begin
        preempt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    kill_d  = 1'b0;
    tgt_d   = tgt_q;
    id_d    = id_q;
    max_d   = max_q;
    mode_d  = mode_q;
`ifdef CLIC_ARB_RR_TIEBREAK_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          valid_d = 1'b1;
          tgt_d   = win_idx;
          id_d    = req_id_i[int'(win_idx)*SrcWidth +: SrcWidth];
          max_d   = req_max_i[int'(win_idx)*PrioWidth +: PrioWidth];
          mode_d  = req_mode_i[int'(win_idx)*ModeWidth +: ModeWidth];
        end
      end
      GRANT: begin
        // A ready handshake wins over a coincident kill ack.
        if (irq_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
`ifdef CLIC_ARB_RR_TIEBREAK_EN
          ptr_d   = (tgt_q == TW'(N_TGT-1)) ? '0 : tgt_q + 1'b1;
`endif
        end else if (!req_valid_i[tgt_q] || (kill_q && irq_kill_ack_i)) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          kill_d  = req_kill_req_i[tgt_q] | preempt;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
      tgt_q   <= '0;
      id_q    <= '0;
      max_q   <= '0;
      mode_q  <= '0;
`ifdef CLIC_ARB_RR_TIEBREAK_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
      tgt_q   <= tgt_d;
      id_q    <= id_d;
      max_q   <= max_d;
      mode_q  <= mode_d;
`ifdef CLIC_ARB_RR_TIEBREAK_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    req_ready_o    = '0;
    req_kill_ack_o = '0;
    if (state_q == GRANT) begin
      req_ready_o[tgt_q]    = irq_ready_i;
      req_kill_ack_o[tgt_q] = irq_kill_ack_i & ~irq_ready_i;
    end
  end

  assign irq_valid_o    = valid_q;
  assign irq_kill_req_o = kill_q;
  assign irq_tgt_o      = tgt_q;
  assign irq_id_o       = id_q;
  assign irq_max_o      = max_q;
  assign irq_mode_o     = mode_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Self-checking bench for clic_irq_arbiter: directed scenarios plus randomized traffic against a key-based model.
module tb_clic_irq_arbiter;
  localparam int N = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req_valid, req_kill_req, req_ready_o, req_kill_ack_o;
  logic [7:0]     t_id [N];
  logic [7:0]     t_prio [N];
  logic [1:0]     t_mode [N];
  logic [N*8-1:0] id_flat, max_flat;
  logic [N*2-1:0] mode_flat;
  logic           irq_valid_o, irq_ready, irq_kill_req_o, kill_ack;
  logic [7:0]     irq_id_o, irq_max_o;
  logic [1:0]     irq_mode_o, irq_tgt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    id_flat   = '0;
    max_flat  = '0;
    mode_flat = '0;
    for (int i = 0; i < N; i++) begin
      id_flat[i*8 +: 8]   = t_id[i];
      max_flat[i*8 +: 8]  = t_prio[i];
      mode_flat[i*2 +: 2] = t_mode[i];
    end
  end

  clic_irq_arbiter #(.N_TGT(N), .SrcWidth(8), .PrioWidth(8), .ModeWidth(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_id_i       (id_flat),
    .req_max_i      (max_flat),
    .req_mode_i     (mode_flat),
    .req_kill_req_i (req_kill_req),
    .req_kill_ack_o (req_kill_ack_o),
    .irq_valid_o    (irq_valid_o),
    .irq_ready_i    (irq_ready),
    .irq_id_o       (irq_id_o),
    .irq_max_o      (irq_max_o),
    .irq_mode_o     (irq_mode_o),
    .irq_tgt_o      (irq_tgt_o),
    .irq_kill_req_o (irq_kill_req_o),
    .irq_kill_ack_i (kill_ack)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid    = '0;
    req_kill_req = '0;
    irq_ready    = 1'b0;
    kill_ack     = 1'b0;
    for (int i = 0; i < N; i++) begin
      t_id[i]   = '0;
      t_prio[i] = '0;
      t_mode[i] = '0;
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] id, input logic [7:0] prio, input logic [1:0] mode);
    req_valid[ch] = 1'b1;
    t_id[ch]      = id;
    t_prio[ch]    = prio;
    t_mode[ch]    = mode;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic settle();
    clear_inputs();
    tick();
    tick();
  endtask

  function automatic int key_of(input int ch);
    return int'(t_mode[ch]) * 256 + int'(t_prio[ch]);
  endfunction

  // Highest key first, then tie resolution over the set of channels holding that key.
  function automatic int model_winner(input logic [N-1:0] v, input int ptr);
    int best = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && key_of(i) > best) best = key_of(i);
    if (best < 0) return -1;
`ifdef CLIC_ARB_RR_TIEBREAK_EN
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N] && key_of((ptr + k) % N) == best) return (ptr + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (v[i] && key_of(i) == best) return i;
`endif
    return -1;
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    #3;
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", irq_valid_o); end
    checks++; if (irq_kill_req_o !== 1'b0) begin errors++; $display("FAIL reset_kill got=%b exp=0", irq_kill_req_o); end
    checks++; if ({irq_id_o, irq_max_o, irq_mode_o, irq_tgt_o} !== 20'h0) begin errors++; $display("FAIL reset_payload got=%h exp=0", {irq_id_o, irq_max_o, irq_mode_o, irq_tgt_o}); end
    checks++; if ({req_ready_o, req_kill_ack_o} !== 8'h0) begin errors++; $display("FAIL reset_req_out got=%h exp=0", {req_ready_o, req_kill_ack_o}); end
    tick();
    rst_ni = 1'b1;
    tick();
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", irq_valid_o); end
  endtask

  task automatic test_single();
    clear_inputs();
    set_ch(2, 8'd5, 8'h40, 2'd3);
    #1;
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL single_pre_valid got=%b exp=0", irq_valid_o); end
    tick();
    checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", irq_valid_o); end
    checks++; if (irq_id_o !== 8'd5 || irq_tgt_o !== 2'd2 || irq_max_o !== 8'h40 || irq_mode_o !== 2'd3) begin
      errors++; $display("FAIL single_payload got id=%0d tgt=%0d max=%h mode=%0d exp id=5 tgt=2 max=40 mode=3", irq_id_o, irq_tgt_o, irq_max_o, irq_mode_o);
    end
    irq_ready = 1'b1;
    #1;
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready_o); end
    tick();
    irq_ready = 1'b0;
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_low got=%b exp=0", irq_valid_o); end
    settle();
  endtask

  task automatic test_priority();
    clear_inputs();
    set_ch(0, 8'd11, 8'h10, 2'd3);
    set_ch(1, 8'd22, 8'h20, 2'd1);
    tick();
    checks++; if (irq_valid_o !== 1'b1 || irq_tgt_o !== 2'd0 || irq_id_o !== 8'd11) begin
      errors++; $display("FAIL prio_mode_dominates got valid=%b tgt=%0d id=%0d exp valid=1 tgt=0 id=11", irq_valid_o, irq_tgt_o, irq_id_o);
    end
    settle();
  endtask

  task automatic test_preempt();
    clear_inputs();
    set_ch(1, 8'd1, 8'h10, 2'd0);
    tick();
    checks++; if (irq_tgt_o !== 2'd1 || irq_kill_req_o !== 1'b0) begin errors++; $display("FAIL preempt_grant got tgt=%0d kill=%b exp tgt=1 kill=0", irq_tgt_o, irq_kill_req_o); end
    set_ch(3, 8'd3, 8'h80, 2'd0);
    tick();
    checks++; if (irq_kill_req_o !== 1'b1 || irq_valid_o !== 1'b1 || irq_tgt_o !== 2'd1) begin
      errors++; $display("FAIL preempt_kill got kill=%b valid=%b tgt=%0d exp kill=1 valid=1 tgt=1", irq_kill_req_o, irq_valid_o, irq_tgt_o);
    end
    kill_ack = 1'b1;
    #1;
    checks++; if (req_kill_ack_o !== 4'b0010) begin errors++; $display("FAIL preempt_kill_ack got=%b exp=0010", req_kill_ack_o); end
    tick();
    kill_ack = 1'b0;
    checks++; if (irq_valid_o !== 1'b0 || irq_kill_req_o !== 1'b0) begin errors++; $display("FAIL preempt_idle got valid=%b kill=%b exp 0 0", irq_valid_o, irq_kill_req_o); end
    tick();
    checks++; if (irq_valid_o !== 1'b1 || irq_tgt_o !== 2'd3 || irq_id_o !== 8'd3) begin
      errors++; $display("FAIL preempt_regrant got valid=%b tgt=%0d id=%0d exp valid=1 tgt=3 id=3", irq_valid_o, irq_tgt_o, irq_id_o);
    end
    settle();
  endtask

  task automatic test_simultaneous();
    int exp_tgt;
    do_reset();
    set_ch(2, 8'd9, 8'h30, 2'd1);
    tick();
    irq_ready = 1'b1;
    kill_ack  = 1'b1;
    #1;
    checks++; if (req_ready_o !== 4'b0100 || req_kill_ack_o !== 4'b0000) begin
      errors++; $display("FAIL simul_fwd got ready=%b kack=%b exp ready=0100 kack=0000", req_ready_o, req_kill_ack_o);
    end
    tick();
    clear_inputs();
    set_ch(1, 8'd1, 8'h30, 2'd1);
    set_ch(3, 8'd3, 8'h30, 2'd1);
`ifdef CLIC_ARB_RR_TIEBREAK_EN
    exp_tgt = 3;
`else
    exp_tgt = 1;
`endif
    tick();
    checks++; if (irq_valid_o !== 1'b1 || irq_tgt_o !== 2'(exp_tgt)) begin
      errors++; $display("FAIL simul_ptr got valid=%b tgt=%0d exp valid=1 tgt=%0d", irq_valid_o, irq_tgt_o, exp_tgt);
    end
    settle();
  endtask

  task automatic test_ties();
    int exp_tgt;
    do_reset();
    set_ch(0, 8'd10, 8'h55, 2'd2);
    set_ch(1, 8'd20, 8'h55, 2'd2);
    for (int i = 0; i < 4; i++) begin
`ifdef CLIC_ARB_RR_TIEBREAK_EN
      exp_tgt = i % 2;
`else
      exp_tgt = 0;
`endif
      tick();
      checks++; if (irq_valid_o !== 1'b1 || irq_tgt_o !== 2'(exp_tgt)) begin
        errors++; $display("FAIL ties_%0d got valid=%b tgt=%0d exp valid=1 tgt=%0d", i, irq_valid_o, irq_tgt_o, exp_tgt);
      end
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
    end
    settle();
  endtask

  task automatic test_reset_in_grant();
    clear_inputs();
    set_ch(2, 8'd77, 8'hF0, 2'd3);
    tick();
    checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL rst_grant_pre got=%b exp=1", irq_valid_o); end
    irq_ready = 1'b1;
    rst_ni    = 1'b0;
    #1;
    checks++; if ({irq_valid_o, irq_kill_req_o, irq_id_o, irq_max_o, irq_mode_o, irq_tgt_o} !== 22'h0) begin
      errors++; $display("FAIL rst_grant_outs got=%h exp=0", {irq_valid_o, irq_kill_req_o, irq_id_o, irq_max_o, irq_mode_o, irq_tgt_o});
    end
    checks++; if ({req_ready_o, req_kill_ack_o} !== 8'h0) begin errors++; $display("FAIL rst_grant_req got=%h exp=0", {req_ready_o, req_kill_ack_o}); end
    tick();
    clear_inputs();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_valid_drop();
    clear_inputs();
    set_ch(1, 8'd4, 8'h22, 2'd0);
    tick();
    checks++; if (irq_valid_o !== 1'b1 || irq_tgt_o !== 2'd1) begin errors++; $display("FAIL drop_grant got valid=%b tgt=%0d exp 1 1", irq_valid_o, irq_tgt_o); end
    req_valid[1] = 1'b0;
    #1;
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL drop_ready got=%b exp=0000", req_ready_o); end
    tick();
    checks++; if (irq_valid_o !== 1'b0 || req_ready_o !== 4'b0000) begin errors++; $display("FAIL drop_idle got valid=%b ready=%b exp 0 0000", irq_valid_o, req_ready_o); end
    settle();
  endtask

  task automatic test_random();
    int m_grant = 0, m_tgt = 0, m_id = 0, m_max = 0, m_mode = 0, m_kill = 0, m_ptr = 0;
    int n_grant, n_tgt, n_id, n_max, n_mode, n_kill, n_ptr, w;
    logic [N-1:0] exp_rdy, exp_kack;
    bit pre;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 3) == 0) begin
          t_prio[i] = ($urandom_range(0, 1) == 1) ? 8'h20 : 8'h10;
          t_mode[i] = 2'($urandom_range(0, 1));
          t_id[i]   = 8'($urandom_range(0, 255));
        end
        req_kill_req[i] = ($urandom_range(0, 9) == 0);
      end
      irq_ready = ($urandom_range(0, 3) == 0);
      kill_ack  = ($urandom_range(0, 2) == 0);
      #1;
      exp_rdy  = '0;
      exp_kack = '0;
      if (m_grant == 1) begin
        exp_rdy[m_tgt]  = irq_ready;
        exp_kack[m_tgt] = kill_ack && !irq_ready;
      end
      checks++; if (req_ready_o !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready_o, exp_rdy); end
      checks++; if (req_kill_ack_o !== exp_kack) begin errors++; $display("FAIL rnd_kack cyc=%0d got=%b exp=%b", c, req_kill_ack_o, exp_kack); end

      n_grant = m_grant; n_tgt = m_tgt; n_id = m_id; n_max = m_max; n_mode = m_mode; n_kill = 0; n_ptr = m_ptr;
      if (m_grant == 0) begin
        w = model_winner(req_valid, m_ptr);
        if (w >= 0) begin
          n_grant = 1; n_tgt = w; n_id = t_id[w]; n_max = t_prio[w]; n_mode = t_mode[w];
        end
      end else if (irq_ready) begin
        n_grant = 0;
        n_ptr   = (m_tgt + 1) % N;
      end else if (!req_valid[m_tgt] || (m_kill == 1 && kill_ack)) begin
        n_grant = 0;
      end else begin
        pre = 0;
        for (int j = 0; j < N; j++)
          if (j != m_tgt && req_valid[j] && key_of(j) > m_mode * 256 + m_max) pre = 1;
        n_kill = (req_kill_req[m_tgt] || pre) ? 1 : 0;
      end
      tick();
      m_grant = n_grant; m_tgt = n_tgt; m_id = n_id; m_max = n_max; m_mode = n_mode; m_kill = n_kill; m_ptr = n_ptr;

      checks++; if (irq_valid_o !== 1'(m_grant)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%0d", c, irq_valid_o, m_grant); end
      checks++; if (irq_kill_req_o !== 1'(m_kill)) begin errors++; $display("FAIL rnd_kill cyc=%0d got=%b exp=%0d", c, irq_kill_req_o, m_kill); end
      if (m_grant == 1) begin
        checks++; if (irq_tgt_o !== 2'(m_tgt) || irq_id_o !== 8'(m_id) || irq_max_o !== 8'(m_max) || irq_mode_o !== 2'(m_mode)) begin
          errors++; $display("FAIL rnd_payload cyc=%0d got tgt=%0d id=%0d max=%h mode=%0d exp tgt=%0d id=%0d max=%h mode=%0d",
                             c, irq_tgt_o, irq_id_o, irq_max_o, irq_mode_o, m_tgt, m_id, m_max, m_mode);
        end
      end
    end
    settle();
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_preempt();
    test_simultaneous();
    test_ties();
    test_reset_in_grant();
    test_valid_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clic_irq_arbiter.md
CLIC_IRQ_ARBITER -- requirements
Module: clic_irq_arbiter

Interface
REQ-001 Parameters SHALL be N_TGT, default 4, number of requesting interrupt-target channels (minimum 2).
REQ-002 Parameters SHALL be SrcWidth, default 8, interrupt ID width.
REQ-003 Parameters SHALL be PrioWidth, default 8, priority width.
REQ-004 Parameters SHALL be ModeWidth, default 2, privilege-mode width.
REQ-005 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 req_valid_i  in  N_TGT  per-channel interrupt request valid.
REQ-008 req_ready_o  out  N_TGT  per-channel accept, one-hot or zero.
REQ-009 req_id_i / req_max_i / req_mode_i  in  N_TGT x SrcWidth / PrioWidth / ModeWidth  per-channel ID, level, mode.
REQ-010 req_kill_req_i  in  N_TGT  per-channel kill request; req_kill_ack_o  out  N_TGT  per-channel kill acknowledge.
REQ-011 irq_valid_o  out  1; irq_ready_i  in  1  core-side handshake.
REQ-012 irq_id_o  out  SrcWidth; irq_max_o  out  PrioWidth; irq_mode_o  out  ModeWidth; irq_tgt_o  out  clog2(N_TGT)  granted channel index.
REQ-013 irq_kill_req_o  out  1; irq_kill_ack_i  in  1  core-side kill handshake.

Function
REQ-014 Arbitration key SHALL be {mode, prio} compared unsigned; higher key wins.
REQ-015 FSM states SHALL be IDLE and GRANT.
REQ-016 IDLE: if any req_valid_i is high, register the winner's index, ID, level and mode, then enter GRANT; irq_valid_o SHALL be high the next cycle (1-cycle latency).
REQ-017 GRANT: irq_valid_o and all irq_* payload outputs SHALL stay stable until the state is left.
REQ-018 GRANT: req_ready_o[g] SHALL equal irq_ready_i combinationally for granted channel g; all other bits SHALL be 0.
REQ-019 GRANT: on irq_valid_o and irq_ready_i, the FSM SHALL return to IDLE; irq_valid_o SHALL be low the next cycle.
REQ-020 GRANT: if req_valid_i[g] deasserts (level IRQ cleared), the FSM SHALL return to IDLE without a ready pulse.
REQ-021 GRANT: irq_kill_req_o SHALL be the registered OR of two causes:
- req_kill_req_i[g];
- preempt, i.e. any other valid channel with a strictly higher key than the registered key.
REQ-022 req_kill_ack_o[g] SHALL equal irq_kill_ack_i while in GRANT; all other bits SHALL be 0.
REQ-023 GRANT: on irq_kill_req_o and irq_kill_ack_i, the FSM SHALL return to IDLE and irq_kill_req_o SHALL be low the next cycle.
REQ-024 Simultaneous irq_ready_i and irq_kill_ack_i SHALL be treated as a completed handshake: ready is forwarded and the kill ack is not forwarded.
REQ-025 irq_valid_o SHALL be low for at least one cycle between consecutive grants.
REQ-026 No req_kill_ack_o or req_ready_o bit SHALL assert in IDLE.

Reset
REQ-027 Asserting rst_ni low SHALL immediately force the FSM to IDLE, from any state including mid-handshake.
REQ-028 While rst_ni is low, irq_valid_o, irq_kill_req_o, irq_id_o, irq_max_o, irq_mode_o and irq_tgt_o SHALL all be 0.
REQ-029 While rst_ni is low, req_ready_o and req_kill_ack_o SHALL be all 0.
REQ-030 The round-robin pointer SHALL reset to 0.

Configuration
REQ-031 Macro CLIC_ARB_RR_TIEBREAK_EN SHALL select the tie-break among channels with equal maximal key.
REQ-032 When CLIC_ARB_RR_TIEBREAK_EN is defined:
- the first tied channel at or after the pointer SHALL win;
- the pointer SHALL move to the granted index+1 (mod N_TGT) on each completed ready handshake.
REQ-033 When CLIC_ARB_RR_TIEBREAK_EN is undefined, the lowest-index tied channel SHALL win and no pointer SHALL exist.

Verification
REQ-034 Single request: ch2 valid with id=5, prio=0x40, mode=3 -> next cycle irq_valid_o=1, irq_id_o=5, irq_tgt_o=2; irq_ready_i=1 -> req_ready_o=4'b0100, then valid low.
REQ-035 Priority: ch0 prio=0x10 mode=3 and ch1 prio=0x20 mode=1 -> ch0 granted, because mode dominates prio.
REQ-036 Preempt: ch1 granted with prio=0x10, ch3 raises prio=0x80 -> irq_kill_req_o=1 next cycle; irq_kill_ack_i=1 -> IDLE, then ch3 granted with a valid gap of 1 or more cycles.
REQ-037 Simultaneous irq_ready_i and irq_kill_ack_i -> req_ready_o[g]=1, req_kill_ack_o=0, pointer advances.
REQ-038 Ties: ch0 and ch1 hold equal key over four handshakes -> with the macro, grants alternate 0,1,0,1; without it, grants are 0,0,0,0.
REQ-039 Reset in GRANT and valid-drop: rst_ni low in GRANT -> all outputs 0 immediately; granted channel drops valid -> irq_valid_o low next cycle with no req_ready_o pulse.
